// File: rtl/logic_op_unit_if.sv
// Request/response handshake bundle for logic_op_unit.
interface logic_op_unit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [1:0]       req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  // Producer/consumer side.
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  // Logic unit side.
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/logic_op_unit.sv
// Handshaked bitwise logic unit with a DEPTH-entry in-order response FIFO.
module logic_op_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  logic_op_unit_if.slave           bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         done_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_NAND = 2'd3;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [CNT_W-1:0] r_done_cnt;
  logic             r_req_ready;
  logic             r_rsp_valid;

  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_result;
  logic [LVL_W-1:0] w_level_nxt;

  assign w_push = bus.req_valid && r_req_ready;
  assign w_pop  = r_rsp_valid && bus.rsp_ready;

  // Bitwise result for the presented operands; only used on acceptance.
  always_comb begin
    w_result = '0;
    case (bus.req_op)
      OP_AND:  w_result = bus.req_a & bus.req_b;
      OP_OR:   w_result = bus.req_a | bus.req_b;
      OP_XOR:  w_result = bus.req_a ^ bus.req_b;
      OP_NAND: w_result = ~(bus.req_a & bus.req_b);
      default: w_result = '0;
    endcase
  end

  // Occupancy after this edge's push/pop.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LVL_W'(1);
      2'b01:   w_level_nxt = r_level - LVL_W'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Storage array; cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_result;
    end
  end

  // Pointers, occupancy, handshake flags and handoff counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_done_cnt  <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
        r_done_cnt <= r_done_cnt + CNT_W'(1);
      end
      r_level     <= w_level_nxt;
      r_req_ready <= (w_level_nxt != LVL_W'(DEPTH));
      r_rsp_valid <= (w_level_nxt != LVL_W'(0));
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_mem[r_rd_ptr];
  assign level         = r_level;
  assign done_cnt      = r_done_cnt;

endmodule

// File: tb/tb_logic_op_unit.sv
// Directed self-checking bench for logic_op_unit (WIDTH=8, DEPTH=4, CNT_W=4).
module tb_logic_op_unit;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [2:0]       level;
  logic [CNT_W-1:0] done_cnt;

  int checks;
  int errors;
  int exp_cnt;

  logic_op_unit_if #(.WIDTH(WIDTH)) bus ();

  logic_op_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .level    (level),
    .done_cnt (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_op    = op;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 2'd0);
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, level, done_cnt} !== {1'b1, 1'b0, 8'h00, 3'd0, 4'd0}) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b data=%h lvl=%0d cnt=%0d, want rdy=1 vld=0 data=00 lvl=0 cnt=0",
               bus.req_ready, bus.rsp_valid, bus.rsp_data, level, done_cnt);
    end
    rst_n = 1'b1;
    exp_cnt = 0;
    tick();
  endtask

  task automatic test_all_ops();
    logic [7:0] exp_r [4];
    exp_r[0] = 8'h40; exp_r[1] = 8'hDF; exp_r[2] = 8'h9F; exp_r[3] = 8'hBF;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hC5, 8'h5A, 2'(i));
      if (i > 0) begin
        checks++;
        if ({bus.rsp_valid, bus.rsp_data, level} !== {1'b1, exp_r[i-1], 3'd1}) begin
          errors++;
          $display("FAIL all_ops[%0d]: vld=%b data=%h lvl=%0d, want vld=1 data=%h lvl=1",
                   i - 1, bus.rsp_valid, bus.rsp_data, level, exp_r[i-1]);
        end
      end
      tick();
    end
    drive(1'b0, 8'h00, 8'h00, 2'd0);
    checks++;
    if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, 8'hBF}) begin
      errors++;
      $display("FAIL all_ops[3]: vld=%b data=%h, want vld=1 data=bf", bus.rsp_valid, bus.rsp_data);
    end
    tick();
    exp_cnt += 4;
    checks++;
    if ({bus.rsp_valid, level, done_cnt} !== {1'b0, 3'd0, 4'(exp_cnt)}) begin
      errors++;
      $display("FAIL all_ops_drain: vld=%b lvl=%0d cnt=%0d, want vld=0 lvl=0 cnt=%0d",
               bus.rsp_valid, level, done_cnt, exp_cnt % 16);
    end
  endtask

  task automatic test_fill_stall();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h10 + i), 8'h0F, 2'd2);
      checks++;
      if ({bus.req_ready, level} !== {1'b1, 3'(i)}) begin
        errors++;
        $display("FAIL fill[%0d]: rdy=%b lvl=%0d, want rdy=1 lvl=%0d", i, bus.req_ready, level, i);
      end
      tick();
    end
    drive(1'b1, 8'h14, 8'h0F, 2'd2);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.req_ready, level, bus.rsp_data} !== {1'b0, 3'd4, 8'h1F}) begin
        errors++;
        $display("FAIL full_stall[%0d]: rdy=%b lvl=%0d data=%h, want rdy=0 lvl=4 data=1f",
                 i, bus.req_ready, level, bus.rsp_data);
      end
      if (i == 2) bus.rsp_ready = 1'b1;
      tick();
    end
    checks++;
    if ({bus.req_ready, level, bus.rsp_data} !== {1'b1, 3'd3, 8'h1E}) begin
      errors++;
      $display("FAIL after_first_pop: rdy=%b lvl=%0d data=%h, want rdy=1 lvl=3 data=1e",
               bus.req_ready, level, bus.rsp_data);
    end
    tick();
    drive(1'b0, 8'h00, 8'h00, 2'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.rsp_valid, level, bus.rsp_data} !== {1'b1, 3'(3 - i), 8'(8'h1D - i)}) begin
        errors++;
        $display("FAIL fill_drain[%0d]: vld=%b lvl=%0d data=%h, want vld=1 lvl=%0d data=%h",
                 i, bus.rsp_valid, level, bus.rsp_data, 3 - i, 8'h1D - i);
      end
      tick();
    end
    exp_cnt += 5;
    checks++;
    if ({bus.rsp_valid, level, done_cnt} !== {1'b0, 3'd0, 4'(exp_cnt)}) begin
      errors++;
      $display("FAIL fill_end: vld=%b lvl=%0d cnt=%0d, want vld=0 lvl=0 cnt=%0d",
               bus.rsp_valid, level, done_cnt, exp_cnt % 16);
    end
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 1'b0;
    drive(1'b1, 8'hAA, 8'h0F, 2'd0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 2'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, done_cnt} !== {1'b1, 8'h0A, 4'(exp_cnt)}) begin
        errors++;
        $display("FAIL hold[%0d]: vld=%b data=%h cnt=%0d, want vld=1 data=0a cnt=%0d",
                 i, bus.rsp_valid, bus.rsp_data, done_cnt, exp_cnt % 16);
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    exp_cnt += 1;
    checks++;
    if ({bus.rsp_valid, level, done_cnt} !== {1'b0, 3'd0, 4'(exp_cnt)}) begin
      errors++;
      $display("FAIL hold_release: vld=%b lvl=%0d cnt=%0d, want vld=0 lvl=0 cnt=%0d",
               bus.rsp_valid, level, done_cnt, exp_cnt % 16);
    end
  endtask

  task automatic test_back_to_back();
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 8'(8'h30 + k), 8'h00, 2'd1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    for (int k = 2; k < 12; k++) begin
      drive(1'b1, 8'(8'h30 + k), 8'h00, 2'd1);
      checks++;
      if ({level, bus.rsp_valid, bus.req_ready, bus.rsp_data} !== {3'd2, 1'b1, 1'b1, 8'(8'h30 + k - 2)}) begin
        errors++;
        $display("FAIL b2b[%0d]: lvl=%0d vld=%b rdy=%b data=%h, want lvl=2 vld=1 rdy=1 data=%h",
                 k, level, bus.rsp_valid, bus.req_ready, bus.rsp_data, 8'h30 + k - 2);
      end
      tick();
    end
    drive(1'b0, 8'h00, 8'h00, 2'd0);
    for (int k = 10; k < 12; k++) begin
      checks++;
      if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, 8'(8'h30 + k)}) begin
        errors++;
        $display("FAIL b2b_drain[%0d]: vld=%b data=%h, want vld=1 data=%h",
                 k, bus.rsp_valid, bus.rsp_data, 8'h30 + k);
      end
      tick();
    end
    exp_cnt += 12;
    checks++;
    if ({level, done_cnt} !== {3'd0, 4'(exp_cnt)}) begin
      errors++;
      $display("FAIL b2b_end: lvl=%0d cnt=%0d, want lvl=0 cnt=%0d", level, done_cnt, exp_cnt % 16);
    end
  endtask

  task automatic test_counter_wrap();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, 8'(k), 8'hFF, 2'd2);
      tick();
    end
    drive(1'b0, 8'h00, 8'h00, 2'd0);
    tick();
    checks++;
    if ({level, done_cnt} !== {3'd0, 4'd1}) begin
      errors++;
      $display("FAIL cnt_wrap: lvl=%0d cnt=%0d, want lvl=0 cnt=1", level, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'h55, 8'h33, 2'd3);
      tick();
    end
    drive(1'b0, 8'h00, 8'h00, 2'd0);
    checks++;
    if ({level, done_cnt} !== {3'd3, 4'd1}) begin
      errors++;
      $display("FAIL pre_reset: lvl=%0d cnt=%0d, want lvl=3 cnt=1", level, done_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, level, done_cnt} !== {1'b1, 1'b0, 8'h00, 3'd0, 4'd0}) begin
      errors++;
      $display("FAIL mid_reset: rdy=%b vld=%b data=%h lvl=%0d cnt=%0d, want rdy=1 vld=0 data=00 lvl=0 cnt=0",
               bus.req_ready, bus.rsp_valid, bus.rsp_data, level, done_cnt);
    end
    #2;
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.rsp_valid, level, done_cnt} !== {1'b0, 3'd0, 4'd0}) begin
        errors++;
        $display("FAIL post_reset[%0d]: vld=%b lvl=%0d cnt=%0d, want vld=0 lvl=0 cnt=0",
                 i, bus.rsp_valid, level, done_cnt);
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = 0;
    test_reset();
    test_all_ops();
    test_fill_stall();
    test_backpressure();
    test_back_to_back();
    test_counter_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
